// File: rtl/hyper_resp_pkg.sv
// Shared types and constants for the HyperBus device-side responder.
package hyper_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WR,
    ST_RD
  } state_e;

  typedef struct packed {
    logic        rw;     // 1 = read
    logic        as;     // 1 = register space
    logic        burst;  // 1 = linear, 0 = wrapped
    logic [28:0] row;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } ca_t;

  localparam logic [15:0] CR0_RESET = 16'h8F1F;
  localparam int unsigned CA_EDGES  = 6;

endpackage

// File: rtl/hyper_resp_edge_det.sv
// Input sampling stage: registers the HyperBus pins once and flags any CK transition.
module hyper_resp_edge_det (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_cs_n,
  input  logic       i_ck,
  input  logic [7:0] i_dq,
  input  logic       i_rwds,
  input  logic       i_hreset_n,
  output logic       o_cs_n,
  output logic       o_ck,
  output logic       o_edge,
  output logic [7:0] o_dq,
  output logic       o_rwds,
  output logic       o_hreset_n
);

  logic       r_cs_n, r_ck, r_ck_d, r_rwds, r_hrst_n;
  logic [7:0] r_dq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cs_n   <= 1'b1;
      r_ck     <= 1'b0;
      r_ck_d   <= 1'b0;
      r_dq     <= '0;
      r_rwds   <= 1'b0;
      r_hrst_n <= 1'b0;
    end else begin
      r_cs_n   <= i_cs_n;
      r_ck     <= i_ck;
      r_ck_d   <= r_ck;
      r_dq     <= i_dq;
      r_rwds   <= i_rwds;
      r_hrst_n <= i_hreset_n;
    end
  end

  // Both CK directions are data edges (DDR); o_ck gives the new level.
  assign o_edge     = r_ck ^ r_ck_d;
  assign o_cs_n     = r_cs_n;
  assign o_ck       = r_ck;
  assign o_dq       = r_dq;
  assign o_rwds     = r_rwds;
  assign o_hreset_n = r_hrst_n;

endmodule

// File: rtl/hyper_mem_responder.sv
// HyperBus memory-side responder: CA decode, initial latency, DDR array/CR0 access.
module hyper_mem_responder
  import hyper_resp_pkg::*;
#(
  parameter int unsigned MemWords      = 1024,
  parameter int unsigned LatencyCycles = 6,
  parameter bit          DoubleLatency = 1'b1,
  parameter int unsigned WrapWords     = 16,
  parameter logic [15:0] DeviceId      = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hyper_reset_ni,
  input  logic        hyper_cs_ni,
  input  logic        hyper_ck_i,
  input  logic [7:0]  hyper_dq_i,
  output logic [7:0]  hyper_dq_o,
  output logic        hyper_dq_oe_o,
  input  logic        hyper_rwds_i,
  output logic        hyper_rwds_o,
  output logic        hyper_rwds_oe_o,
  output logic [15:0] cr0_o,
  output logic        proto_err_o
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam int unsigned WB       = $clog2(WrapWords);
  localparam int unsigned Leff     = DoubleLatency ? 2 * LatencyCycles : LatencyCycles;
  localparam int unsigned FirstMem = CA_EDGES + 2 * Leff;

  logic       w_cs_n, w_ck, w_edge, w_rwds, w_hrst_n;
  logic [7:0] w_dq;

  hyper_resp_edge_det u_edge_det (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_cs_n     (hyper_cs_ni),
    .i_ck       (hyper_ck_i),
    .i_dq       (hyper_dq_i),
    .i_rwds     (hyper_rwds_i),
    .i_hreset_n (hyper_reset_ni),
    .o_cs_n     (w_cs_n),
    .o_ck       (w_ck),
    .o_edge     (w_edge),
    .o_dq       (w_dq),
    .o_rwds     (w_rwds),
    .o_hreset_n (w_hrst_n)
  );

  state_e        r_state, w_state_n;
  ca_t           r_ca;
  logic [7:0]    r_edge_cnt, w_first_edge;
  logic [31:0]   r_addr;
  logic [15:0]   r_cr0, w_rd_word;
  logic [15:0]   r_mem [MemWords];
  logic [7:0]    r_dq;
  logic          r_dq_oe, r_rwds, r_rwds_oe, r_err;
  logic          w_beat, w_err, w_wr_beat, w_rd_beat;
  logic [AW-1:0] w_idx;

  function automatic logic [31:0] f_next_addr(input logic [31:0] a, input logic lin);
    if (lin) return a + 32'd1;
    return {a[31:WB], a[WB-1:0] + WB'(1)};
  endfunction

  assign w_idx        = r_addr[AW-1:0];
  assign w_first_edge = (r_ca.as && !r_ca.rw) ? 8'(CA_EDGES) : 8'(FirstMem);
  assign w_wr_beat    = w_beat && (w_state_n == ST_WR);
  assign w_rd_beat    = w_beat && (w_state_n == ST_RD);

  // The first data edge is consumed while leaving LAT, so WR/RD only ever see data edges.
  always_comb begin
    w_state_n = r_state;
    w_err     = 1'b0;
    w_beat    = 1'b0;
    if (!w_hrst_n) begin
      w_state_n = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (!w_cs_n) w_state_n = ST_CA;
    end else if (w_cs_n) begin
      w_state_n = ST_IDLE;
      w_err     = (r_state == ST_CA) || (r_state == ST_LAT);
    end else if (w_edge) begin
      case (r_state)
        ST_CA:   if (r_edge_cnt == 8'(CA_EDGES - 1)) w_state_n = ST_LAT;
        ST_LAT:  if (r_edge_cnt == w_first_edge) begin
                   w_state_n = r_ca.rw ? ST_RD : ST_WR;
                   w_beat    = 1'b1;
                 end
        default: w_beat = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (r_ca.as) begin
      if (r_addr == 32'd0)      w_rd_word = DeviceId;
      else if (r_addr == 32'd1) w_rd_word = r_cr0;
    end else begin
      w_rd_word = r_mem[w_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_edge_cnt <= '0;
      r_ca       <= '0;
      r_addr     <= '0;
      r_cr0      <= CR0_RESET;
      r_dq       <= '0;
      r_dq_oe    <= 1'b0;
      r_rwds     <= 1'b0;
      r_rwds_oe  <= 1'b0;
      r_err      <= 1'b0;
    end else if (!w_hrst_n) begin
      r_edge_cnt <= '0;
      r_ca       <= '0;
      r_addr     <= '0;
      r_cr0      <= CR0_RESET;
      r_dq       <= '0;
      r_dq_oe    <= 1'b0;
      r_rwds     <= 1'b0;
      r_rwds_oe  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_err;
      if (r_state == ST_IDLE)
        r_edge_cnt <= '0;
      else if (w_edge && (r_state == ST_CA || r_state == ST_LAT))
        r_edge_cnt <= r_edge_cnt + 8'd1;
      if (r_state == ST_CA && w_edge)
        r_ca <= {r_ca[39:0], w_dq};
      // CA is complete throughout LAT; the address is held steady from then on.
      if (r_state == ST_LAT && !w_beat)
        r_addr <= {r_ca.row, r_ca.col};
      else if ((w_wr_beat || w_rd_beat) && !w_ck)
        r_addr <= f_next_addr(r_addr, r_ca.burst);
      if (w_wr_beat && r_ca.as) begin
        if (w_ck) r_cr0[15:8] <= w_dq;
        else      r_cr0[7:0]  <= w_dq;
      end
      r_dq_oe   <= (w_state_n == ST_RD);
      r_rwds_oe <= (w_state_n == ST_CA) || (w_state_n == ST_RD);
      if (w_state_n == ST_CA)      r_rwds <= DoubleLatency;
      else if (w_rd_beat)          r_rwds <= w_ck;
      else if (w_state_n != ST_RD) r_rwds <= 1'b0;
      if (w_rd_beat)               r_dq <= w_ck ? w_rd_word[15:8] : w_rd_word[7:0];
      else if (w_state_n != ST_RD) r_dq <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_beat && !r_ca.as && !w_rwds) begin
      if (w_ck) r_mem[w_idx][15:8] <= w_dq;
      else      r_mem[w_idx][7:0]  <= w_dq;
    end
  end

  assign hyper_dq_o      = r_dq;
  assign hyper_dq_oe_o   = r_dq_oe;
  assign hyper_rwds_o    = r_rwds;
  assign hyper_rwds_oe_o = r_rwds_oe;
  assign cr0_o           = r_cr0;
  assign proto_err_o     = r_err;

endmodule

// File: tb/tb_hyper_mem_responder.sv
// Directed bench for hyper_mem_responder: table of bus transfers plus abort/reset sequences.
module tb_hyper_mem_responder;

  localparam int HALF       = 3;   // clk_i cycles per CK half period
  localparam int LEFF       = 12;  // 2 * LatencyCycles (double latency)
  localparam int FIRST_DATA = 30;  // edge index of first mem data beat

  logic        clk = 1'b0;
  logic        rst_n, hrst_n, cs_n, ck, rwds_i;
  logic [7:0]  dq_i;
  logic [7:0]  dq_o;
  logic        dq_oe_o, rwds_o, rwds_oe_o, proto_err_o;
  logic [15:0] cr0_o;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  always #5 clk = ~clk;

  hyper_mem_responder #(
    .MemWords      (1024),
    .LatencyCycles (6),
    .DoubleLatency (1'b1),
    .WrapWords     (16),
    .DeviceId      (16'h0C81)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .hyper_reset_ni  (hrst_n),
    .hyper_cs_ni     (cs_n),
    .hyper_ck_i      (ck),
    .hyper_dq_i      (dq_i),
    .hyper_dq_o      (dq_o),
    .hyper_dq_oe_o   (dq_oe_o),
    .hyper_rwds_i    (rwds_i),
    .hyper_rwds_o    (rwds_o),
    .hyper_rwds_oe_o (rwds_oe_o),
    .cr0_o           (cr0_o),
    .proto_err_o     (proto_err_o)
  );

  always @(negedge clk) if (proto_err_o === 1'b1) err_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        rd;
    logic        rs;
    logic        lin;
    logic [31:0] addr;
    logic [2:0]  nw;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [63:0] exp_rd;
    logic [15:0] exp_cr0;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic rs, input logic lin,
                              input logic [31:0] a, input logic [2:0] nw,
                              input logic [63:0] wd, input logic [7:0] wm,
                              input logic [63:0] er, input logic [15:0] cr);
    vec_t v;
    v.rd = rd; v.rs = rs; v.lin = lin; v.addr = a; v.nw = nw;
    v.wd = wd; v.wm = wm; v.exp_rd = er; v.exp_cr0 = cr;
    return v;
  endfunction

  task automatic check(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic m);
    dq_i   = d;
    rwds_i = m;
    ck     = ~ck;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_xfer(input logic rd, input logic rs, input logic lin, input logic [31:0] a,
                         input int nw, input logic [63:0] wd, input logic [7:0] wm,
                         output logic [63:0] rdw, output logic [7:0] strb,
                         output int first_oe, output logic ca_ok);
    logic [47:0] ca;
    int e;
    int nlat;
    ca       = {rd, rs, lin, a[31:3], 13'h0, a[2:0]};
    rdw      = '0;
    strb     = '0;
    first_oe = -1;
    ca_ok    = 1'b1;
    e        = 0;
    nlat     = (rs && !rd) ? 0 : 2 * LEFF;
    cs_n     = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      ck_edge(ca[47-8*i -: 8], 1'b0);
      if (i < 5 && !(rwds_oe_o === 1'b1 && rwds_o === 1'b1)) ca_ok = 1'b0;
      if (first_oe < 0 && dq_oe_o === 1'b1) first_oe = e;
      e++;
    end
    for (int i = 0; i < nlat; i++) begin
      ck_edge(8'h00, 1'b0);
      if (first_oe < 0 && dq_oe_o === 1'b1) first_oe = e;
      e++;
    end
    for (int k = 0; k < 2 * nw; k++) begin
      ck_edge(rd ? 8'h00 : wd[63-8*k -: 8], rd ? 1'b0 : wm[7-k]);
      if (first_oe < 0 && dq_oe_o === 1'b1) first_oe = e;
      if (rd) begin
        rdw[63-8*k -: 8] = dq_o;
        strb[7-k]        = rwds_o;
      end
      e++;
    end
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  localparam int NV = 20;
  vec_t vecs [NV];

  logic [63:0] rdw;
  logic [7:0]  strb, strb_exp;
  int          first_oe, err_base;
  logic        ca_ok;
  logic [47:0] ca_tmp;

  initial begin
    vecs[0]  = mk(0, 0, 1, 32'h010, 2, 64'hA5A5_1234_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[1]  = mk(1, 0, 1, 32'h010, 2, 64'h0, 8'h00, 64'hA5A5_1234_0000_0000, 16'h8F1F);
    vecs[2]  = mk(0, 0, 1, 32'h020, 1, 64'hFFFF_0000_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[3]  = mk(0, 0, 1, 32'h020, 1, 64'h0000_0000_0000_0000, 8'h80, 64'h0, 16'h8F1F);
    vecs[4]  = mk(1, 0, 1, 32'h020, 1, 64'h0, 8'h00, 64'hFF00_0000_0000_0000, 16'h8F1F);
    vecs[5]  = mk(0, 0, 1, 32'h00E, 2, 64'h0E0E_0F0F_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[6]  = mk(0, 0, 1, 32'h000, 2, 64'hAAA0_AAA1_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[7]  = mk(1, 0, 0, 32'h00E, 4, 64'h0, 8'h00, 64'h0E0E_0F0F_AAA0_AAA1, 16'h8F1F);
    vecs[8]  = mk(0, 0, 0, 32'h03F, 2, 64'h5A5A_C3C3_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[9]  = mk(1, 0, 1, 32'h030, 1, 64'h0, 8'h00, 64'hC3C3_0000_0000_0000, 16'h8F1F);
    vecs[10] = mk(1, 0, 1, 32'h03F, 1, 64'h0, 8'h00, 64'h5A5A_0000_0000_0000, 16'h8F1F);
    vecs[11] = mk(0, 0, 1, 32'h3FF, 2, 64'h7777_8888_0000_0000, 8'h00, 64'h0, 16'h8F1F);
    vecs[12] = mk(1, 0, 1, 32'h400, 1, 64'h0, 8'h00, 64'h8888_0000_0000_0000, 16'h8F1F);
    vecs[13] = mk(1, 0, 1, 32'h3FF, 2, 64'h0, 8'h00, 64'h7777_8888_0000_0000, 16'h8F1F);
    vecs[14] = mk(1, 1, 1, 32'h000, 1, 64'h0, 8'h00, 64'h0C81_0000_0000_0000, 16'h8F1F);
    vecs[15] = mk(1, 1, 1, 32'h001, 1, 64'h0, 8'h00, 64'h8F1F_0000_0000_0000, 16'h8F1F);
    vecs[16] = mk(0, 1, 1, 32'h001, 1, 64'h8F17_0000_0000_0000, 8'h00, 64'h0, 16'h8F17);
    vecs[17] = mk(1, 1, 1, 32'h001, 1, 64'h0, 8'h00, 64'h8F17_0000_0000_0000, 16'h8F17);
    vecs[18] = mk(1, 1, 1, 32'h002, 1, 64'h0, 8'h00, 64'h0000_0000_0000_0000, 16'h8F17);
    vecs[19] = mk(1, 1, 1, 32'h000, 2, 64'h0, 8'h00, 64'h0C81_8F17_0000_0000, 16'h8F17);

    rst_n = 1'b0; hrst_n = 1'b1; cs_n = 1'b1; ck = 1'b0; dq_i = '0; rwds_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", -1, {52'h0, dq_o, dq_oe_o, rwds_o, rwds_oe_o, proto_err_o},
          {52'h0, 8'h00, 4'b0000});
    check("reset_cr0", -1, {48'h0, cr0_o}, {48'h0, 16'h8F1F});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      do_xfer(vecs[v].rd, vecs[v].rs, vecs[v].lin, vecs[v].addr, int'(vecs[v].nw),
              vecs[v].wd, vecs[v].wm, rdw, strb, first_oe, ca_ok);
      check("ca_rwds_latency_flag", v, {63'h0, ca_ok}, 64'h1);
      check("cr0", v, {48'h0, cr0_o}, {48'h0, vecs[v].exp_cr0});
      if (vecs[v].rd) begin
        strb_exp = '0;
        for (int k = 0; k < 2 * int'(vecs[v].nw); k++) strb_exp[7-k] = (k % 2 == 0);
        check("read_data", v, rdw, vecs[v].exp_rd);
        check("read_strobe", v, {56'h0, strb}, {56'h0, strb_exp});
        check("first_data_edge", v, 64'(first_oe), 64'(FIRST_DATA));
      end else begin
        check("write_no_dq_oe", v, 64'(first_oe), 64'(-1));
      end
    end
    check("no_err_in_normal_bursts", -1, 64'(err_cnt), 64'(0));

    // CS raised after CA byte 3, then during latency.
    err_base = err_cnt;
    ca_tmp   = {1'b1, 1'b0, 1'b1, 29'h2, 13'h0, 3'h0};
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) ck_edge(ca_tmp[47-8*i -: 8], 1'b0);
    check("rwds_oe_during_ca", 100, {63'h0, rwds_oe_o}, 64'h1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("oe_low_after_abort", 100, {62'h0, rwds_oe_o, dq_oe_o}, 64'h0);
    repeat (4) @(negedge clk);
    check("proto_err_ca_pulse", 100, 64'(err_cnt - err_base), 64'(1));

    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) ck_edge(ca_tmp[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 4; i++) ck_edge(8'h00, 1'b0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("proto_err_lat_pulse", 101, 64'(err_cnt - err_base), 64'(2));

    do_xfer(1, 0, 1, 32'h010, 2, 64'h0, 8'h00, rdw, strb, first_oe, ca_ok);
    check("read_after_abort", 102, rdw, 64'hA5A5_1234_0000_0000);
    check("first_edge_after_abort", 102, 64'(first_oe), 64'(FIRST_DATA));

    // Device reset mid-burst: CR0 back to reset value, array kept, no error pulse.
    do_xfer(0, 1, 1, 32'h001, 1, 64'h1234_0000_0000_0000, 8'h00, rdw, strb, first_oe, ca_ok);
    check("cr0_before_dev_reset", 103, {48'h0, cr0_o}, {48'h0, 16'h1234});
    err_base = err_cnt;
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) ck_edge(ca_tmp[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 2; i++) ck_edge(8'h00, 1'b0);
    hrst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("cr0_dev_reset", 103, {48'h0, cr0_o}, {48'h0, 16'h8F1F});
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    hrst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_err_on_dev_reset", 103, 64'(err_cnt - err_base), 64'(0));
    do_xfer(1, 0, 1, 32'h010, 2, 64'h0, 8'h00, rdw, strb, first_oe, ca_ok);
    check("array_kept_after_dev_reset", 104, rdw, 64'hA5A5_1234_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
